// File: rtl/huff_pkg.sv
// Shared types for the Huffman decode front end.
// FIFO entry layout, serializer FSM states and width helpers.
package huff_pkg;

    localparam int HUFF_W  = 8;
    localparam int HUFF_NB = $clog2(HUFF_W + 1);

    typedef struct packed {
        logic [HUFF_W-1:0]  data;
        logic               last;
        logic [HUFF_NB-1:0] nbits;
    } fifo_entry_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } ser_state_t;

    // Bits to emit for a word: full width unless a last word says otherwise.
    function automatic logic [HUFF_NB-1:0] nbits_eff(
        input logic               last,
        input logic [HUFF_NB-1:0] nb
    );
        if (!last || nb == '0 || nb > HUFF_NB'(HUFF_W))
            return HUFF_NB'(HUFF_W);
        return nb;
    endfunction

endpackage

// File: rtl/huff_bit_serializer_if.sv
// Word input handshake and serial bit output of the serializer.
// master = upstream/downstream environment, slave = serializer.
interface huff_bit_serializer_if
    import huff_pkg::*;
#(
    parameter int W  = HUFF_W,
    parameter int NB = $clog2(W + 1)
);
    logic [W-1:0]  in_data;
    logic          in_last;
    logic [NB-1:0] in_nbits;
    logic          in_valid;
    logic          in_ready;
    logic          bit_ready;
    logic          serial_d;
    logic          c_en;
    logic          stream_done;

    modport master (
        output in_data, in_last, in_nbits, in_valid, bit_ready,
        input  in_ready, serial_d, c_en, stream_done
    );

    modport slave (
        input  in_data, in_last, in_nbits, in_valid, bit_ready,
        output in_ready, serial_d, c_en, stream_done
    );
endinterface

// File: rtl/huff_word_fifo.sv
// Single-clock word FIFO with wrap-bit pointers.
// Head entry is visible combinationally on rdata_o.
module huff_word_fifo
    import huff_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        push_i,
    input  fifo_entry_t wdata_i,
    input  logic        pop_i,
    output fifo_entry_t rdata_o,
    output logic        full_o,
    output logic        empty_o
);
    localparam int AW = $clog2(DEPTH);

    fifo_entry_t    mem_q [DEPTH];
    logic [AW:0]    wr_q, wr_d;
    logic [AW:0]    rd_q, rd_d;
    logic           do_push, do_pop;

    assign full_o  = (wr_q[AW] != rd_q[AW]) &&
                     (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign empty_o = (wr_q == rd_q);
    assign rdata_o = mem_q[rd_q[AW-1:0]];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer advance on accepted push / pop.
    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers; reset empties the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write; contents need no reset.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/huff_bit_serializer.sv
// Shifts buffered code words out MSB first, one bit per cycle.
// Refills back-to-back so the bit stream has no word-boundary gaps.
module huff_bit_serializer
    import huff_pkg::*;
#(
    parameter int W     = HUFF_W,
    parameter int DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    huff_bit_serializer_if.slave  bus
);
    localparam int NB = $clog2(W + 1);

    ser_state_t    state_q, state_d;
    logic [W-1:0]  shreg_q, shreg_d;
    logic [NB-1:0] left_q, left_d;
    logic          last_q, last_d;

    logic          full, empty, push, pop, go;
    fifo_entry_t   head, wentry;

    assign bus.in_ready = !full && !rst;
    assign push         = bus.in_valid && bus.in_ready;
    assign wentry       = {bus.in_data, bus.in_last, bus.in_nbits};
    assign go           = bus.bit_ready;

    huff_word_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .wdata_i (wentry),
        .pop_i   (pop),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty)
    );

    // State and shifter registers; everything holds while go is low.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= '0;
            left_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            left_q  <= left_d;
            last_q  <= last_d;
        end
    end

    // Next state and FIFO pop decision.
    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (go && !empty) begin
                    pop     = 1'b1;
                    state_d = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (go && left_q == NB'(1)) begin
                    if (last_q)      state_d = S_DONE;
                    else if (!empty) pop     = 1'b1;
                    else             state_d = S_IDLE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Shifter update: load on pop wins over shifting the spent word.
    always_comb begin
        shreg_d = shreg_q;
        left_d  = left_q;
        last_d  = last_q;
        if (pop) begin
            shreg_d = head.data;
            left_d  = nbits_eff(head.last, head.nbits);
            last_d  = head.last;
        end else if (state_q == S_SHIFT && go) begin
            shreg_d = {shreg_q[W-2:0], 1'b0};
            left_d  = left_q - NB'(1);
        end
    end

    // Serial outputs decoded from registered state.
    always_comb begin
        bus.c_en        = (state_q == S_SHIFT) && go;
        bus.serial_d    = shreg_q[W-1];
        bus.stream_done = (state_q == S_DONE);
    end

endmodule

// File: tb/tb_huff_bit_serializer.sv
// Scoreboard bench for huff_bit_serializer.
// Accepted words expand into an expected bit/done queue; a monitor pops it.
module tb_huff_bit_serializer;
    import huff_pkg::*;

    localparam int W  = HUFF_W;
    localparam int NB = HUFF_NB;
    localparam int DONE_TOKEN = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    huff_bit_serializer_if #(.W(W)) bus ();

    huff_bit_serializer #(.W(W), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int exp_q[$];
    int cen_cnt   = 0;
    int first_cyc = -1;
    int last_cyc  = -1;
    int acc_cyc   = 0;
    int br_mode   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    // Reference: a word contributes its first k bits MSB first, plus an
    // end-of-stream token when it is a last word.
    task automatic model_word(input logic [W-1:0] d, input bit last,
                              input int nb);
        int k;
        k = (!last || nb == 0 || nb > W) ? W : nb;
        for (int i = 0; i < k; i++) exp_q.push_back(int'(d[W-1-i]));
        if (last) exp_q.push_back(DONE_TOKEN);
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic push_word(input logic [W-1:0] d, input bit last,
                             input int nb);
        bus.in_data  = d;
        bus.in_last  = last;
        bus.in_nbits = NB'(nb);
        bus.in_valid = 1'b1;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                acc_cyc = cyc;
                model_word(d, last, nb);
                @(posedge clk);
                #1;
                bus.in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        check("push_timeout", 0, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(input int budget);
        for (int t = 0; t < budget; t++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        check("drain_queue_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic clear_stats();
        cen_cnt   = 0;
        first_cyc = -1;
        last_cyc  = -1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // bit_ready pattern generator for the stall tests.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (br_mode == 1) bus.bit_ready = ($urandom_range(0, 3) != 0);
            else if (br_mode == 2) bus.bit_ready = !bus.bit_ready;
        end
    end

    // Monitor: every consumed bit and every done pulse pops the scoreboard.
    always @(negedge clk) begin : mon
        int e;
        if (!rst) begin
            if (bus.c_en) begin
                check("bit_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("serial_bit", int'(bus.serial_d), e);
                end
                cen_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (bus.stream_done) begin
                check("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("done_token", e, DONE_TOKEN);
                end
                check("done_timing", cyc, last_cyc + 1);
            end
        end
    end

    initial begin
        int saved;
        logic [W-1:0] d;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.in_nbits  = '0;
        bus.in_valid  = 1'b0;
        bus.bit_ready = 1'b0;

        // Reset values
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", int'(bus.in_ready), 0);
        check("rst_c_en", int'(bus.c_en), 0);
        check("rst_serial_d", int'(bus.serial_d), 0);
        check("rst_stream_done", int'(bus.stream_done), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", int'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Single full last word, latency N+2
        bus.bit_ready = 1'b1;
        clear_stats();
        push_word(8'b1101_0110, 1'b1, 8);
        saved = acc_cyc;
        drain(100);
        check("latency_first_c_en", first_cyc, saved + 2);
        check("single_word_bits", cen_cnt, 8);

        // Three back-to-back words, gap-free
        clear_stats();
        push_word(8'hFF, 1'b0, 0);
        push_word(8'h00, 1'b0, 0);
        push_word(8'hA5, 1'b1, 8);
        drain(200);
        check("b2b_bits", cen_cnt, 24);
        check("b2b_span", last_cyc - first_cyc + 1, 24);

        // FIFO fills at DEPTH while stalled; 5th word is held
        bus.bit_ready = 1'b0;
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(W'($urandom), 1'b0, 0);
        @(negedge clk);
        check("full_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        fork
            push_word(W'($urandom), 1'b1, 8);
        join_none
        repeat (3) begin
            @(negedge clk);
            check("held_in_ready", int'(bus.in_ready), 0);
            check("stalled_c_en", int'(bus.c_en), 0);
        end
        @(posedge clk);
        #1;
        bus.bit_ready = 1'b1;
        drain(400);
        wait fork;
        check("full_release_bits", cen_cnt, 40);

        // Partial last words
        clear_stats();
        d = {3'b101, 5'($urandom)};
        push_word(d, 1'b1, 3);
        drain(100);
        check("nbits3_bits", cen_cnt, 3);
        clear_stats();
        push_word(W'($urandom), 1'b1, 0);
        drain(100);
        check("nbits0_bits", cen_cnt, 8);
        clear_stats();
        push_word(W'($urandom), 1'b1, 12);
        drain(100);
        check("nbits_over_bits", cen_cnt, 8);

        // bit_ready toggling every cycle
        clear_stats();
        br_mode = 2;
        push_word(8'h96, 1'b1, 8);
        drain(200);
        br_mode = 0;
        bus.bit_ready = 1'b1;
        check("toggle_bits", cen_cnt, 8);
        check("toggle_span", last_cyc - first_cyc, 14);

        // Reset mid-word with two words still queued
        bus.bit_ready = 1'b0;
        for (int i = 0; i < 3; i++) push_word(W'($urandom), 1'b0, 0);
        clear_stats();
        bus.bit_ready = 1'b1;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (cen_cnt >= 3) break;
        end
        check("pre_rst_bits", int'(cen_cnt >= 3), 1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("mid_rst_in_ready", int'(bus.in_ready), 0);
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        @(negedge clk);
        check("after_rst_c_en", int'(bus.c_en), 0);
        check("after_rst_in_ready", int'(bus.in_ready), 1);
        saved = cen_cnt;
        repeat (4) @(negedge clk);
        check("after_rst_fifo_empty", cen_cnt - saved, 0);
        @(posedge clk);
        #1;
        clear_stats();
        push_word(8'h3C, 1'b1, 8);
        drain(100);
        check("after_rst_word_bits", cen_cnt, 8);

        // Randomized streams with random stalls and gaps
        br_mode = 1;
        for (int i = 0; i < 40; i++) begin
            push_word(W'($urandom), ($urandom_range(0, 3) == 0),
                      $urandom_range(0, 15));
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        push_word(W'($urandom), 1'b1, $urandom_range(1, 8));
        br_mode = 0;
        bus.bit_ready = 1'b1;
        drain(3000);

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
